// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM word, RAM handshake state, arbiter FSM state.
package memory_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single owner of the RAM port: arbitrates icache fetches against dcache loads/stores.
// Data has priority; a saturating starvation counter forces an instruction grant
// after STARVE_MAX consecutive data completions while a fetch is pending.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t       state;
    arb_state_t       next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_full;
    logic             dreq;
    logic             i_done;
    logic             d_done;

    assign dreq        = dREN | dWEN;
    assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));

    // State register; reset aborts any grant in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Starvation counter: counts data completions that bypassed a pending fetch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (!iREN || i_done) begin
            starve_cnt <= '0;
        end else if (d_done && !starve_full) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Next-state decision and grant-phase outputs (combinational from state + inputs).
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;

        case (state)
            IDLE: begin
                if (dreq && !(iREN && starve_full)) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end

            DGRANT: begin
                if (!dreq) begin
                    // Requester withdrew: no RAM operation, no completion.
                    next_state = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ramstate == ACCESS) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        d_done     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == ACCESS) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        i_done     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int unsigned STARVE_MAX = 4;
    localparam logic [31:0] IADDR  = 32'h0000_0040;
    localparam logic [31:0] DADDR  = 32'h0000_0080;
    localparam logic [31:0] DSTORE = 32'hDEAD_BEEF;
    localparam logic [31:0] RLOAD  = 32'h2001_0005;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    memory_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_iw, input logic e_dw,
                           input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                           input logic [31:0] e_store, input logic [31:0] e_il,
                           input logic [31:0] e_dl);
        chk({tag, ".iwait"},    32'(iwait),  32'(e_iw));
        chk({tag, ".dwait"},    32'(dwait),  32'(e_dw));
        chk({tag, ".ramREN"},   32'(ramREN), 32'(e_ren));
        chk({tag, ".ramWEN"},   32'(ramWEN), 32'(e_wen));
        chk({tag, ".ramaddr"},  ramaddr,     e_addr);
        chk({tag, ".ramstore"}, ramstore,    e_store);
        chk({tag, ".iload"},    iload,       e_il);
        chk({tag, ".dload"},    dload,       e_dl);
    endtask

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = icache, 2 = dcache; starve = data wins over a waiting fetch
    int m_owner;
    int m_starve;

    task automatic model_cycle(input string tag);
        logic        e_iw, e_dw, e_ren, e_wen;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        bit          i_fin, d_fin, dwant;
        int          nxt;
        e_iw = 1'b1; e_dw = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
        e_addr = '0; e_store = '0; e_il = '0; e_dl = '0;
        i_fin = 0; d_fin = 0; nxt = m_owner;
        dwant = (dREN || dWEN);
        if (m_owner == 0) begin
            if (dwant && !(iREN && m_starve >= int'(STARVE_MAX))) nxt = 2;
            else if (iREN) nxt = 1;
        end else if (m_owner == 1) begin
            if (iREN) begin
                e_ren  = 1'b1;
                e_addr = iaddr;
                if (ramstate == ACCESS) begin
                    e_iw = 1'b0; e_il = ramload; i_fin = 1;
                end
            end
            if (!iREN || i_fin) nxt = 0;
        end else begin
            if (dwant) begin
                e_addr = daddr;
                if (dWEN) begin
                    e_wen = 1'b1; e_store = dstore;
                end else begin
                    e_ren = 1'b1;
                end
                if (ramstate == ACCESS) begin
                    e_dw = 1'b0; e_dl = ramload; d_fin = 1;
                end
            end
            if (!dwant || d_fin) nxt = 0;
        end
        chk_all(tag, e_iw, e_dw, e_ren, e_wen, e_addr, e_store, e_il, e_dl);
        chk({tag, ".onewait"}, 32'(iwait | dwait), 32'd1);
        if (!iREN || i_fin)                             m_starve = 0;
        else if (d_fin && m_starve < int'(STARVE_MAX))  m_starve = m_starve + 1;
        m_owner = nxt;
    endtask

    // ---------------- helpers ----------------
    task automatic idle_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = IADDR; daddr = DADDR; dstore = DSTORE;
        ramload = RLOAD; ramstate = FREE;
    endtask

    task automatic do_reset(input string tag);
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        idle_inputs();
        #4;
        chk_all(tag, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        m_owner  = 0;
        m_starve = 0;
    endtask

    // drive at posedge+1, sample at posedge+5
    task automatic cyc(input logic ir, input logic dr, input logic dw, input logic [1:0] rs);
        @(posedge CLK);
        #1;
        iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
        #4;
    endtask

    typedef struct {
        logic        iren;
        logic        dren;
        logic        dwen;
        logic [1:0]  rs;
        logic        e_iw;
        logic        e_dw;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic dr, input logic dw,
                                input logic [1:0] rs, input logic iw, input logic dwt,
                                input logic ren, input logic wen, input logic [31:0] addr);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dw; v.rs = rs;
        v.e_iw = iw; v.e_dw = dwt; v.e_ren = ren; v.e_wen = wen; v.e_addr = addr;
        return v;
    endfunction

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte         got[10];
        byte         exp_order[10];
        int          n;
        int          ilow;
        string       tag;

        nRST = 1'b0;
        idle_inputs();
        m_owner = 0;
        m_starve = 0;

        // ---- vector table: simultaneous I+D write, then fetch with 2-cycle RAM latency ----
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, FREE,   1'b1, 1'b1, 1'b0, 1'b0, '0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, BUSY,   1'b1, 1'b1, 1'b0, 1'b1, DADDR);
        vecs[2]  = mk(1'b1, 1'b0, 1'b1, ACCESS, 1'b1, 1'b0, 1'b0, 1'b1, DADDR);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, FREE,   1'b1, 1'b1, 1'b0, 1'b0, '0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, BUSY,   1'b1, 1'b1, 1'b1, 1'b0, IADDR);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, ACCESS, 1'b0, 1'b1, 1'b1, 1'b0, IADDR);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, FREE,   1'b1, 1'b1, 1'b0, 1'b0, '0);
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, FREE,   1'b1, 1'b1, 1'b0, 1'b0, '0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, BUSY,   1'b1, 1'b1, 1'b1, 1'b0, IADDR);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, BUSY,   1'b1, 1'b1, 1'b1, 1'b0, IADDR);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, ACCESS, 1'b0, 1'b1, 1'b1, 1'b0, IADDR);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, FREE,   1'b1, 1'b1, 1'b0, 1'b0, '0);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, FREE,   1'b1, 1'b1, 1'b0, 1'b0, '0);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, ACCESS, 1'b1, 1'b0, 1'b1, 1'b0, DADDR);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, FREE,   1'b1, 1'b1, 1'b0, 1'b0, '0);

        do_reset("reset0");
        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].rs);
            tag = $sformatf("vec%0d", i);
            chk_all(tag, vecs[i].e_iw, vecs[i].e_dw, vecs[i].e_ren, vecs[i].e_wen,
                    vecs[i].e_addr, vecs[i].e_wen ? DSTORE : 32'h0,
                    vecs[i].e_iw ? 32'h0 : RLOAD, vecs[i].e_dw ? 32'h0 : RLOAD);
        end

        // ---- asynchronous reset in the middle of a data grant ----
        do_reset("reset1");
        cyc(1'b0, 1'b1, 1'b0, FREE);
        cyc(1'b0, 1'b1, 1'b0, BUSY);
        chk("rst.pre_ren", 32'(ramREN), 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk_all("rst.async", 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        #4;
        chk("rst.idle_ren", 32'(ramREN), 32'd0);
        chk("rst.idle_dwait", 32'(dwait), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, BUSY);
        chk("rst.regrant_ren", 32'(ramREN), 32'd1);

        // ---- ERROR retries during an instruction grant ----
        do_reset("reset2");
        cyc(1'b1, 1'b0, 1'b0, FREE);
        ilow = 0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0, ERROR);
            chk($sformatf("err%0d.iwait", k), 32'(iwait), 32'd1);
            chk($sformatf("err%0d.ramREN", k), 32'(ramREN), 32'd1);
            chk($sformatf("err%0d.ramaddr", k), ramaddr, IADDR);
        end
        cyc(1'b1, 1'b0, 1'b0, ACCESS);
        if (!iwait) ilow++;
        chk("err.iload", iload, RLOAD);
        cyc(1'b1, 1'b0, 1'b0, ACCESS);
        if (!iwait) ilow++;
        chk("err.bubble_ren", 32'(ramREN), 32'd0);
        chk("err.completions", 32'(ilow), 32'd1);

        // ---- data request withdrawn while BUSY; pending fetch then served ----
        do_reset("reset3");
        cyc(1'b1, 1'b1, 1'b0, FREE);
        cyc(1'b1, 1'b1, 1'b0, BUSY);
        chk("drop.grant_ren", 32'(ramREN), 32'd1);
        chk("drop.grant_addr", ramaddr, DADDR);
        cyc(1'b1, 1'b0, 1'b0, BUSY);
        chk("drop.no_op_ren", 32'(ramREN), 32'd0);
        chk("drop.dwait", 32'(dwait), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, ACCESS);
        chk("drop.idle_ren", 32'(ramREN), 32'd0);
        chk("drop.idle_dwait", 32'(dwait), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, ACCESS);
        chk_all("drop.igrant", 1'b0, 1'b1, 1'b1, 1'b0, IADDR, '0, RLOAD, '0);

        // ---- starvation: fetch held high under a continuous data storm ----
        do_reset("reset4");
        exp_order = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            cyc(1'b1, 1'b1, 1'b0, ACCESS);
            if (!dwait) begin
                got[n] = "D";
                n++;
            end else if (!iwait) begin
                got[n] = "I";
                n++;
            end
        end
        if (n < 10) chk("starve.timeout", 32'(n), 32'd10);
        for (int i = 0; i < n; i++)
            chk($sformatf("starve.order%0d", i), 32'(got[i]), 32'(exp_order[i]));

        // ---- randomized traffic against the reference model ----
        do_reset("reset5");
        for (int c = 0; c < 1500; c++) begin
            int r;
            @(posedge CLK);
            #1;
            iREN     = ($urandom_range(0, 3) != 0);
            r        = int'($urandom_range(0, 3));
            dREN     = (r == 1 || r == 3);
            dWEN     = (r >= 2);
            ramstate = 2'($urandom_range(0, 3));
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            #4;
            model_cycle($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
